ram_port_arbiter: RTL and testbench

//  Owns the shared 64K SRAM port: muxes the flash boot loader, the CPU bus and the

---
 rtl/ram_port_arbiter_pkg.sv | 34 +++
 rtl/ram_port_arbiter_if.sv | 75 +++++++
 rtl/ram_port_arbiter_region_table.sv | 80 ++++++++
 rtl/ram_port_arbiter.sv | 136 +++++++++++++
 tb/tb_ram_port_arbiter.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/ram_port_arbiter_pkg.sv
// Shared types for the RAM port arbiter: FSM states, RAM channel select
// and the default character-bank register address.
package ram_port_pkg;

    localparam int unsigned BANK_ADDR_DEFAULT = 59468;
    localparam int unsigned DRAIN_CNT_W       = 4;

    // Encoding is visible on the state output: BOOT=0 RUN=1 DRAIN=2 HALTED=3.
    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        CH_BOOT = 2'd0,
        CH_CPU  = 2'd1,
        CH_DIAG = 2'd2
    } chan_t;

    // DRAIN keeps the CPU on the port so an in-flight cycle can finish.
    function automatic chan_t chan_of(input state_t s);
        chan_t c;
        case (s)
            ST_BOOT:   c = CH_BOOT;
            ST_RUN:    c = CH_CPU;
            ST_DRAIN:  c = CH_CPU;
            default:   c = CH_DIAG;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Bus bundle between the RAM port arbiter and its neighbours: loader, CPU,
// diagnostics, SRAM, region-table config and VRAM mirror stream.
interface ram_port_arbiter_if #(
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned CFG_BITS = 4,
    parameter int unsigned VRAM_AW  = 11
);
    logic                boot_done;
    logic [ADDR_W-1:0]   boot_addr;
    logic [DATA_W-1:0]   boot_wdata;
    logic                boot_cs;
    logic                boot_we;

    logic [ADDR_W-1:0]   cpu_addr;
    logic [DATA_W-1:0]   cpu_wdata;
    logic                cpu_cs;
    logic                cpu_we;
    logic [DATA_W-1:0]   cpu_rdata;
    logic                cpu_rdy;

    logic                diag_halt_req;
    logic [ADDR_W-1:0]   diag_addr;
    logic [DATA_W-1:0]   diag_wdata;
    logic                diag_cs;
    logic                diag_we;
    logic                halt_ack;

    logic [ADDR_W-1:0]   ram_addr;
    logic [DATA_W-1:0]   ram_wdata;
    logic                ram_cs;
    logic                ram_we;
    logic [DATA_W-1:0]   ram_rdata;

    logic [CFG_BITS-1:0] cfg_sel;
    logic                tbl_wr;
    logic [CFG_BITS-1:0] tbl_idx;
    logic [ADDR_W-1:0]   tbl_start;
    logic [ADDR_W-1:0]   tbl_end;

    logic                vram_we;
    logic [VRAM_AW-1:0]  vram_waddr;
    logic [DATA_W-1:0]   vram_wdata;

    logic [1:0]          state;

    // Arbiter side.
    modport slave (
        input  boot_done, boot_addr, boot_wdata, boot_cs, boot_we,
        input  cpu_addr, cpu_wdata, cpu_cs, cpu_we,
        output cpu_rdata, cpu_rdy,
        input  diag_halt_req, diag_addr, diag_wdata, diag_cs, diag_we,
        output halt_ack,
        output ram_addr, ram_wdata, ram_cs, ram_we,
        input  ram_rdata,
        input  cfg_sel, tbl_wr, tbl_idx, tbl_start, tbl_end,
        output vram_we, vram_waddr, vram_wdata,
        output state
    );

    // Environment side.
    modport master (
        output boot_done, boot_addr, boot_wdata, boot_cs, boot_we,
        output cpu_addr, cpu_wdata, cpu_cs, cpu_we,
        input  cpu_rdata, cpu_rdy,
        output diag_halt_req, diag_addr, diag_wdata, diag_cs, diag_we,
        input  halt_ack,
        input  ram_addr, ram_wdata, ram_cs, ram_we,
        output ram_rdata,
        output cfg_sel, tbl_wr, tbl_idx, tbl_start, tbl_end,
        input  vram_we, vram_waddr, vram_wdata,
        input  state
    );

endinterface

// File: rtl/ram_port_arbiter_region_table.sv
// VRAM region table: one [start,end) window per configuration. Every RAM
// write that lands in the active window (or on the char-bank register) is
// re-issued one cycle later as a VRAM write at its offset in the window.
module vram_region_table #(
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned CFG_BITS  = 4,
    parameter int unsigned VRAM_AW   = 11,
    parameter int unsigned BANK_ADDR = 59468
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [CFG_BITS-1:0] i_cfg,
    input  logic                i_tbl_wr,
    input  logic [CFG_BITS-1:0] i_tbl_idx,
    input  logic [ADDR_W-1:0]   i_tbl_start,
    input  logic [ADDR_W-1:0]   i_tbl_end,
    input  logic [ADDR_W-1:0]   i_ram_addr,
    input  logic [DATA_W-1:0]   i_ram_wdata,
    input  logic                i_ram_cs,
    input  logic                i_ram_we,
    output logic                o_vram_we,
    output logic [VRAM_AW-1:0]  o_vram_waddr,
    output logic [DATA_W-1:0]   o_vram_wdata
);

    localparam int unsigned DEPTH = 2 ** CFG_BITS;

    logic [ADDR_W-1:0]  r_start [DEPTH];
    logic [ADDR_W-1:0]  r_end   [DEPTH];

    logic [ADDR_W-1:0]  w_start;
    logic [ADDR_W-1:0]  w_end;
    logic               w_bank;
    logic               w_in_region;
    logic               w_hit;
    logic [VRAM_AW-1:0] w_waddr;

    // Entry storage; a write becomes visible to the compare on the next cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_start[i] <= '0;
                r_end[i]   <= '0;
            end
        end else if (i_tbl_wr) begin
            r_start[i_tbl_idx] <= i_tbl_start;
            r_end[i_tbl_idx]   <= i_tbl_end;
        end
    end

    // Hit detection and window offset; an empty window (end<=start) only
    // ever matches the char-bank register, which maps to the last VRAM byte.
    always_comb begin
        w_start     = r_start[i_cfg];
        w_end       = r_end[i_cfg];
        w_bank      = (i_ram_addr == ADDR_W'(BANK_ADDR));
        w_in_region = (i_ram_addr >= w_start) && (i_ram_addr < w_end);
        w_hit       = i_ram_we && i_ram_cs && (w_in_region || w_bank);
        if (w_bank) begin
            w_waddr = VRAM_AW'(w_end - w_start - ADDR_W'(1));
        end else begin
            w_waddr = VRAM_AW'(i_ram_addr - w_start);
        end
    end

    // Registered mirror-write stream.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_vram_we    <= 1'b0;
            o_vram_waddr <= '0;
            o_vram_wdata <= '0;
        end else begin
            o_vram_we    <= w_hit;
            o_vram_waddr <= w_waddr;
            o_vram_wdata <= i_ram_wdata;
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shared 64K SRAM port owner: sequences BOOT -> RUN -> DRAIN -> HALTED,
// muxes loader / CPU / diagnostics onto the RAM port, drives CPU RDY and
// the halt handshake, and feeds the VRAM mirror table.
module ram_port_arbiter
    import ram_port_pkg::*;
#(
    parameter int unsigned ADDR_W       = 16,
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned CFG_BITS     = 4,
    parameter int unsigned VRAM_AW      = 11,
    parameter int unsigned DRAIN_CYCLES = 2,
    parameter int unsigned BANK_ADDR    = BANK_ADDR_DEFAULT
) (
    input logic          i_clk,
    input logic          i_rst,
    ram_port_arbiter_if.slave bus
);

    state_t                 r_state;
    logic [DRAIN_CNT_W-1:0] r_drain_cnt;
    logic                   r_cpu_rdy;
    logic                   r_halt_ack;
    logic [CFG_BITS-1:0]    r_cfg_q;
    chan_t                  w_chan;

    // Sequencer with registered RDY/ack. Leaving BOOT, RDY rises one cycle
    // after RUN entry; on all other transitions RDY/ack track the new state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_BOOT;
            r_drain_cnt <= '0;
            r_cpu_rdy   <= 1'b0;
            r_halt_ack  <= 1'b0;
            r_cfg_q     <= '0;
        end else begin
            case (r_state)
                ST_BOOT: begin
                    r_cpu_rdy  <= 1'b0;
                    r_halt_ack <= 1'b0;
                    if (bus.boot_done) begin
                        r_state <= ST_RUN;
                        r_cfg_q <= bus.cfg_sel;
                    end
                end
                ST_RUN: begin
                    if (bus.diag_halt_req) begin
                        r_state     <= ST_DRAIN;
                        r_drain_cnt <= DRAIN_CNT_W'(1);
                        r_cpu_rdy   <= 1'b0;
                    end else begin
                        r_cpu_rdy   <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (!bus.diag_halt_req) begin
                        r_state     <= ST_RUN;
                        r_drain_cnt <= '0;
                        r_cpu_rdy   <= 1'b1;
                    end else if (r_drain_cnt >= DRAIN_CNT_W'(DRAIN_CYCLES)) begin
                        r_state     <= ST_HALTED;
                        r_drain_cnt <= '0;
                        r_halt_ack  <= 1'b1;
                    end else begin
                        r_drain_cnt <= r_drain_cnt + DRAIN_CNT_W'(1);
                    end
                end
                default: begin
                    r_cfg_q <= bus.cfg_sel;
                    if (!bus.diag_halt_req) begin
                        r_state    <= ST_RUN;
                        r_halt_ack <= 1'b0;
                        r_cpu_rdy  <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign w_chan = chan_of(r_state);

    // Zero-latency RAM port mux driven from the state register.
    always_comb begin
        bus.ram_addr  = bus.boot_addr;
        bus.ram_wdata = bus.boot_wdata;
        bus.ram_cs    = bus.boot_cs;
        bus.ram_we    = bus.boot_we;
        case (w_chan)
            CH_CPU: begin
                bus.ram_addr  = bus.cpu_addr;
                bus.ram_wdata = bus.cpu_wdata;
                bus.ram_cs    = bus.cpu_cs;
                bus.ram_we    = bus.cpu_we;
            end
            CH_DIAG: begin
                bus.ram_addr  = bus.diag_addr;
                bus.ram_wdata = bus.diag_wdata;
                bus.ram_cs    = bus.diag_cs;
                bus.ram_we    = bus.diag_we;
            end
            default: ;
        endcase
    end

    // CPU read data is forced to zero outside RUN.
    always_comb begin
        bus.cpu_rdata = (r_state == ST_RUN) ? bus.ram_rdata : '0;
    end

    assign bus.cpu_rdy  = r_cpu_rdy;
    assign bus.halt_ack = r_halt_ack;
    assign bus.state    = r_state;

    vram_region_table #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .CFG_BITS  (CFG_BITS),
        .VRAM_AW   (VRAM_AW),
        .BANK_ADDR (BANK_ADDR)
    ) u_region_table (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_cfg        (r_cfg_q),
        .i_tbl_wr     (bus.tbl_wr),
        .i_tbl_idx    (bus.tbl_idx),
        .i_tbl_start  (bus.tbl_start),
        .i_tbl_end    (bus.tbl_end),
        .i_ram_addr   (bus.ram_addr),
        .i_ram_wdata  (bus.ram_wdata),
        .i_ram_cs     (bus.ram_cs),
        .i_ram_we     (bus.ram_we),
        .o_vram_we    (bus.vram_we),
        .o_vram_waddr (bus.vram_waddr),
        .o_vram_wdata (bus.vram_wdata)
    );

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural 64K SRAM.
module tb_ram_port_arbiter;

    logic clk;
    logic rst;
    int   n_assert;
    int   n_fail;

    ram_port_arbiter_if #(
        .ADDR_W   (16),
        .DATA_W   (8),
        .CFG_BITS (4),
        .VRAM_AW  (11)
    ) bus ();

    ram_port_arbiter #(
        .ADDR_W       (16),
        .DATA_W       (8),
        .CFG_BITS     (4),
        .VRAM_AW      (11),
        .DRAIN_CYCLES (2),
        .BANK_ADDR    (59468)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    logic [7:0] mem [0:65535];

    always @(posedge clk) begin
        if (bus.ram_cs && bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
    end
    assign bus.ram_rdata = mem[bus.ram_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d);
        bus.cpu_addr  = a;
        bus.cpu_wdata = d;
        bus.cpu_cs    = 1'b1;
        bus.cpu_we    = 1'b1;
    endtask

    task automatic tbl(input logic [3:0] idx, input logic [15:0] s, input logic [15:0] e);
        bus.tbl_wr    = 1'b1;
        bus.tbl_idx   = idx;
        bus.tbl_start = s;
        bus.tbl_end   = e;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst = 1'b1;
        bus.boot_done = 0; bus.boot_addr = '0; bus.boot_wdata = '0; bus.boot_cs = 0; bus.boot_we = 0;
        bus.cpu_addr = '0; bus.cpu_wdata = '0; bus.cpu_cs = 0; bus.cpu_we = 0;
        bus.diag_halt_req = 0; bus.diag_addr = '0; bus.diag_wdata = '0; bus.diag_cs = 0; bus.diag_we = 0;
        bus.cfg_sel = '0; bus.tbl_wr = 0; bus.tbl_idx = '0; bus.tbl_start = '0; bus.tbl_end = '0;
        cyc();
        cyc();

        // Reset state
        chk("rst_state",  32'(bus.state), 0);
        chk("rst_rdy",    32'(bus.cpu_rdy), 0);
        chk("rst_ack",    32'(bus.halt_ack), 0);
        chk("rst_vwe",    32'(bus.vram_we), 0);
        chk("rst_vaddr",  32'(bus.vram_waddr), 0);
        chk("rst_vdata",  32'(bus.vram_wdata), 0);

        // 1: boot load, then RUN
        rst = 1'b0;
        bus.boot_addr = 16'h1234; bus.boot_wdata = 8'hAA; bus.boot_cs = 1; bus.boot_we = 1;
        #1;
        chk("boot_mux_addr", 32'(bus.ram_addr), 'h1234);
        chk("boot_mux_we",   32'(bus.ram_we), 1);
        chk("boot_mux_data", 32'(bus.ram_wdata), 'hAA);
        cyc();
        chk("boot_state", 32'(bus.state), 0);
        chk("boot_vwe",   32'(bus.vram_we), 0);
        bus.boot_cs = 0; bus.boot_we = 0; bus.boot_done = 1; bus.cfg_sel = 4'd3;
        #1;
        chk("boot_done_state", 32'(bus.state), 0);
        cyc();
        chk("run_entry_state", 32'(bus.state), 1);
        chk("run_entry_rdy",   32'(bus.cpu_rdy), 0);
        bus.boot_done = 0;
        cyc();
        chk("run_sticky_state", 32'(bus.state), 1);
        chk("run_rdy",          32'(bus.cpu_rdy), 1);
        bus.cpu_addr = 16'h1234; bus.cpu_cs = 1; bus.cpu_we = 0;
        #1;
        chk("cpu_read", 32'(bus.cpu_rdata), 'hAA);

        // 2: halt with two drain cycles
        bus.diag_halt_req = 1;
        cyc();
        chk("drain1_state", 32'(bus.state), 2);
        chk("drain1_rdy",   32'(bus.cpu_rdy), 0);
        chk("drain1_ack",   32'(bus.halt_ack), 0);
        chk("drain1_rdata", 32'(bus.cpu_rdata), 0);
        cyc();
        chk("drain2_ack", 32'(bus.halt_ack), 0);
        cyc();
        chk("halt_ack",   32'(bus.halt_ack), 1);
        chk("halt_state", 32'(bus.state), 3);
        bus.cpu_addr = 16'h0000; bus.cpu_cs = 0;
        bus.diag_addr = 16'h1234; bus.diag_cs = 1; bus.diag_we = 0;
        #1;
        chk("diag_mux_addr", 32'(bus.ram_addr), 'h1234);
        chk("diag_rdata",    32'(bus.ram_rdata), 'hAA);
        chk("halt_cpu_rdata", 32'(bus.cpu_rdata), 0);
        bus.diag_halt_req = 0; bus.diag_cs = 0;
        cyc();
        chk("resume_state", 32'(bus.state), 1);
        chk("resume_ack",   32'(bus.halt_ack), 0);
        chk("resume_rdy",   32'(bus.cpu_rdy), 1);

        // 3: aborted drain
        bus.diag_halt_req = 1;
        cyc();
        chk("abort_drain_state", 32'(bus.state), 2);
        chk("abort_drain_ack",   32'(bus.halt_ack), 0);
        bus.diag_halt_req = 0;
        cyc();
        chk("abort_run_state", 32'(bus.state), 1);
        chk("abort_run_ack",   32'(bus.halt_ack), 0);

        // 4: region mirror; cfg_sel change outside HALTED has no effect
        bus.cfg_sel = 4'd5;
        tbl(4'd3, 16'h8000, 16'h8800);
        cpu_wr(16'h8005, 8'h5A);
        cyc();
        chk("tbl_same_cycle_vwe", 32'(bus.vram_we), 0);
        bus.tbl_wr = 0;
        cyc();
        chk("mirror_vwe",   32'(bus.vram_we), 1);
        chk("mirror_waddr", 32'(bus.vram_waddr), 5);
        chk("mirror_wdata", 32'(bus.vram_wdata), 'h5A);
        cpu_wr(16'h8800, 8'h11);
        cyc();
        chk("mirror_end_vwe", 32'(bus.vram_we), 0);
        cpu_wr(16'h87FF, 8'h22);
        cyc();
        chk("mirror_last_vwe",   32'(bus.vram_we), 1);
        chk("mirror_last_waddr", 32'(bus.vram_waddr), 'h7FF);
        cpu_wr(16'd59468, 8'h0E);
        cyc();
        chk("bank_vwe",   32'(bus.vram_we), 1);
        chk("bank_waddr", 32'(bus.vram_waddr), 'h7FF);
        chk("bank_wdata", 32'(bus.vram_wdata), 'h0E);
        cpu_wr(16'h8005, 8'h5A);
        bus.cpu_cs = 0;
        cyc();
        chk("no_cs_vwe", 32'(bus.vram_we), 0);

        // 5: empty region
        tbl(4'd3, 16'h9000, 16'h9000);
        cyc();
        bus.tbl_wr = 0;
        cpu_wr(16'h9000, 8'h33);
        cyc();
        chk("empty_vwe", 32'(bus.vram_we), 0);
        cpu_wr(16'd59468, 8'h44);
        cyc();
        chk("empty_bank_vwe",   32'(bus.vram_we), 1);
        chk("empty_bank_waddr", 32'(bus.vram_waddr), 'h7FF);
        chk("empty_bank_wdata", 32'(bus.vram_wdata), 'h44);
        bus.cpu_cs = 0; bus.cpu_we = 0;

        // 6: reset while HALTED, then halt request held through BOOT
        tbl(4'd0, 16'h0100, 16'h0200);
        cyc();
        bus.tbl_wr = 0;
        bus.diag_halt_req = 1;
        cyc();
        cyc();
        cyc();
        chk("pre_rst_ack", 32'(bus.halt_ack), 1);
        rst = 1'b1;
        cyc();
        chk("rst_halt_state", 32'(bus.state), 0);
        chk("rst_halt_ack",   32'(bus.halt_ack), 0);
        chk("rst_halt_rdy",   32'(bus.cpu_rdy), 0);
        rst = 1'b0;
        bus.boot_addr = 16'h0105; bus.boot_wdata = 8'h66; bus.boot_cs = 1; bus.boot_we = 1;
        cyc();
        chk("boot_req_ignored", 32'(bus.state), 0);
        chk("tbl_cleared_vwe",  32'(bus.vram_we), 0);
        bus.boot_cs = 0; bus.boot_we = 0;
        tbl(4'd0, 16'h0100, 16'h0200);
        cyc();
        bus.tbl_wr = 0;
        bus.boot_wdata = 8'h77; bus.boot_cs = 1; bus.boot_we = 1;
        cyc();
        chk("boot_mirror_vwe",   32'(bus.vram_we), 1);
        chk("boot_mirror_waddr", 32'(bus.vram_waddr), 5);
        chk("boot_mirror_wdata", 32'(bus.vram_wdata), 'h77);
        bus.boot_cs = 0; bus.boot_we = 0; bus.boot_done = 1;
        cyc();
        chk("boot_req_run", 32'(bus.state), 1);
        cyc();
        chk("boot_req_drain",     32'(bus.state), 2);
        chk("boot_req_drain_rdy", 32'(bus.cpu_rdy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
